// File: rtl/microcpu_pkg.sv
// Shared definitions for the microcpu: opcodes, sequencer state encoding and default widths.
package microcpu_pkg;

    localparam int PC_WIDTH_DEF    = 12;
    localparam int INSTR_WIDTH_DEF = 16;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] MUL = 4'd3;
    localparam logic [3:0] AND = 4'd4;
    localparam logic [3:0] OR  = 4'd5;
    localparam logic [3:0] JMP = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4
    } seq_state_e;

    // Opcodes that produce a register-file result; everything else (incl. undefined) acts as NOP.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == ADD) || (op == SUB) || (op == MUL) || (op == AND) || (op == OR);
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_reg.sv
// Program counter register: synchronous reset, load has priority over increment, wraps modulo 2^PC_WIDTH.
module pc_reg #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [PC_WIDTH-1:0] i_load_val,
    input  logic                i_inc,
    output logic [PC_WIDTH-1:0] o_pc
);

    logic [PC_WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= PC_RESET;
        else if (i_load)
            r_pc <= i_load_val;
        else if (i_inc)
            r_pc <= r_pc + PC_WIDTH'(1);
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns PC, instruction register and retire count.
module cpu_sequencer
    import microcpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] PC_RESET    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   load_pc,
    input  logic [PC_WIDTH-1:0]    load_pc_val,
    output logic                   exec_en,
    output logic                   rf_we,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic [15:0]            retired
);

    seq_state_e             r_state;
    seq_state_e             w_next_state;
    seq_state_e             w_boundary;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [15:0]            r_retired;
    logic [PC_WIDTH-1:0]    w_pc;
    logic [3:0]             w_opcode;
    logic                   w_alu;
    logic                   w_pc_load;
    logic                   w_pc_inc;

    assign w_opcode   = r_instr[INSTR_WIDTH-1 -: 4];
    assign w_alu      = is_alu_op(w_opcode);
    assign w_boundary = run ? ST_FETCH : ST_IDLE;

    // A jump in EXECUTE wins over the opcode; ALU ops defer the PC step to WRITEBACK.
    assign w_pc_load = (r_state == ST_EXECUTE) && load_pc;
    assign w_pc_inc  = ((r_state == ST_EXECUTE) && !load_pc && !w_alu) ||
                       (r_state == ST_WRITEBACK);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      w_next_state = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:     w_next_state = imem_ack ? ST_DECODE : ST_FETCH;
            ST_DECODE:    w_next_state = ST_EXECUTE;
            ST_EXECUTE:   w_next_state = (!load_pc && w_alu) ? ST_WRITEBACK : w_boundary;
            ST_WRITEBACK: w_next_state = w_boundary;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        exec_en  = 1'b0;
        rf_we    = 1'b0;
        busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_FETCH:     imem_req = 1'b1;
            ST_EXECUTE:   exec_en  = 1'b1;
            ST_WRITEBACK: rf_we    = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_instr <= '0;
        else if ((r_state == ST_FETCH) && imem_ack)
            r_instr <= imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_retired <= '0;
        else if (w_pc_load || w_pc_inc)
            r_retired <= r_retired + 16'd1;
    end

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (load_pc_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    assign pc        = w_pc;
    assign imem_addr = w_pc;
    assign instr     = r_instr;
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: cycle-accurate expected-output queue filled from a small ISA model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        load_pc;
    logic [11:0] load_pc_val;
    logic        exec_en;
    logic        rf_we;
    logic [11:0] pc;
    logic        busy;
    logic [15:0] retired;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .load_pc     (load_pc),
        .load_pc_val (load_pc_val),
        .exec_en     (exec_en),
        .rf_we       (rf_we),
        .pc          (pc),
        .busy        (busy),
        .retired     (retired)
    );

    // Stand-in for control_unit: JMP target is the low 12 bits of the instruction.
    assign load_pc     = (instr[15:12] == 4'd6);
    assign load_pc_val = instr[11:0];

    logic [15:0] mem [0:4095];
    int          wait_cyc [0:4095];
    logic        mem_en;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        force_ack;
    logic [15:0] force_data;
    int          wcnt;

    assign imem_ack   = mem_ack | force_ack;
    assign imem_rdata = force_ack ? force_data : mem_rdata;

    // Memory responder: acks after wait_cyc[addr] stall cycles.
    always @(negedge clk) begin
        if (mem_en && imem_req) begin
            if (wcnt >= wait_cyc[imem_addr]) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[imem_addr];
                wcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    typedef struct packed {
        logic        req;
        logic [11:0] addr;
        logic        ex;
        logic        we;
        logic [11:0] pc;
        logic [15:0] ret;
        logic        busy;
        logic [15:0] instr;
    } obs_t;

    obs_t        exp_q[$];
    logic [11:0] mpc;
    logic [15:0] mret;
    logic [15:0] minstr;
    int          errors = 0;
    int          checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.req   = imem_req;
        o.addr  = imem_addr;
        o.ex    = exec_en;
        o.we    = rf_we;
        o.pc    = pc;
        o.ret   = retired;
        o.busy  = busy;
        o.instr = instr;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("req=%b addr=%h ex=%b we=%b pc=%h ret=%0d busy=%b instr=%h",
                         o.req, o.addr, o.ex, o.we, o.pc, o.ret, o.busy, o.instr);
    endfunction

    task automatic push_cycle(input logic req, input logic ex, input logic we, input logic bsy);
        obs_t e;
        e.req   = req;
        e.addr  = mpc;
        e.ex    = ex;
        e.we    = we;
        e.pc    = mpc;
        e.ret   = mret;
        e.busy  = bsy;
        e.instr = minstr;
        exp_q.push_back(e);
    endtask

    // Expected cycles for one instruction fetched at mpc with the given stall count.
    task automatic push_instr(input int waits);
        logic [15:0] w;
        logic [3:0]  op;
        w  = mem[mpc];
        op = w[15:12];
        wait_cyc[mpc] = waits;
        for (int i = 0; i <= waits; i++) push_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        minstr = w;
        push_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        push_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        if (op >= 4'd1 && op <= 4'd5) begin
            push_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            mpc = mpc + 12'd1;
        end else if (op == 4'd6) begin
            mpc = w[11:0];
        end else begin
            mpc = mpc + 12'd1;
        end
        mret = mret + 16'd1;
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        rst = 1'b1;
        run = 1'b0;
        tick();
        tick();
        mpc = 12'h000; mret = 16'd0; minstr = 16'h0000;
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset: got %s / expected %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_alu();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        mem[0] = 16'h1123;
        rst = 1'b0;
        run = 1'b1;
        push_instr(0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alu cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_jmp_wait();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        mem[1] = 16'h6040;
        push_instr(2);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jmp_wait cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_pc_wrap();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        mem[12'h040] = 16'h6FFF;
        mem[12'hFFF] = 16'h0000;
        push_instr(0);
        push_instr(1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pc_wrap cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_undef_op();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        mem[0] = 16'hF123;
        push_instr(0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL undef_op cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_run_drop();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        mem[1] = 16'h1123;
        mem[2] = 16'h1123;
        push_instr(0);
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_drop cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            if (cyc == 1) run = 1'b0;
            cyc++;
        end
        // Resume: fetch restarts at the advanced pc.
        wait_cyc[2] = 5;
        run = 1'b1;
        push_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        e = exp_q.pop_front();
        o = sample();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL run_resume: got %s / expected %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_mid_fetch();
        obs_t o;
        obs_t e;
        int   cyc = 0;
        push_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        e = exp_q.pop_front();
        o = sample();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL stall_fetch: got %s / expected %s", fmt(o), fmt(e));
        end
        // Reset collides with an ack carrying a new word: reset must win.
        rst        = 1'b1;
        mem_en     = 1'b0;
        force_ack  = 1'b1;
        force_data = 16'h2ABC;
        mpc = 12'h000; mret = 16'd0; minstr = 16'h0000;
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            tick();
            if (cyc == 0) begin
                rst = 1'b0;
                run = 1'b0;
            end
            e = exp_q.pop_front();
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_fetch cyc%0d: got %s / expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
        end
        force_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]      = 16'h0000;
            wait_cyc[i] = 0;
        end
        rst        = 1'b1;
        run        = 1'b0;
        mem_en     = 1'b1;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        force_ack  = 1'b0;
        force_data = 16'h0000;
        wcnt       = 0;

        test_reset();
        test_alu();
        test_jmp_wait();
        test_pc_wrap();
        test_undef_op();
        test_run_drop();
        test_reset_mid_fetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit microcpu.
- Owns the 12-bit program counter and the instruction register.
- Fetches from instruction memory over a req/ack handshake.
- Presents the instruction to control_unit and pulses ALU-execute and register-file-write strobes.
- Applies JMP redirects from control_unit's load_pc/load_pc_val.

Parameters:
PC_WIDTH, 12, program counter / instruction memory address width
INSTR_WIDTH, 16, instruction width
PC_RESET, 0, PC value after reset

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  enable; sampled only at instruction boundaries
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address; equals pc while imem_req high
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_WIDTH  fetched instruction
instr  out  INSTR_WIDTH  instruction register, drives control_unit
load_pc  in  1  jump request from control_unit
load_pc_val  in  PC_WIDTH  jump target from control_unit
exec_en  out  1  one-cycle ALU execute strobe
rf_we  out  1  one-cycle register-file write strobe (dest = instr[3:0])
pc  out  PC_WIDTH  current program counter
busy  out  1  high in every state except IDLE
retired  out  16  retired-instruction count, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, pc=PC_RESET, instr=0, retired=0; imem_req, exec_en, rf_we and busy all 0. Reset overrides everything, including mid-fetch: imem_req is low the cycle after rst is sampled.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK. Encoding is defined in the package.
- IDLE: all strobes 0. If run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack is ignored outside FETCH.
  - On imem_ack: instr<=imem_rdata and go to DECODE. A zero-wait ack in the first FETCH cycle is legal.
- DECODE: one cycle; control_unit settles on instr. Go to EXECUTE.
- EXECUTE: exec_en=1 for exactly this cycle. Transition by opcode=instr[15:12]:
  - load_pc=1 (JMP, opcode 6): pc<=load_pc_val; retired++; go to boundary.
  - Opcode 0 (NOP) or 7..15 (undefined, treated as NOP): pc<=pc+1; retired++; go to boundary.
  - Opcode 1..5 (ADD/SUB/MUL/AND/OR): go to WRITEBACK; pc unchanged.
- WRITEBACK: rf_we=1 for exactly this cycle; pc<=pc+1; retired++; go to boundary.
- Boundary: go to FETCH if run=1, else IDLE. run is ignored mid-instruction; an instruction in flight always completes.
- PC arithmetic is modulo 2^PC_WIDTH: pc=0xFFF increments to 0x000. A JMP target is taken verbatim, including a target equal to the JMP's own address (self-loop is legal).
- Latency with zero-wait memory:
  - ALU op: 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK).
  - JMP/NOP: 3 cycles.
  - Each imem wait cycle adds 1.
- Simultaneous events:
  - rst with imem_ack: rst wins; instr is not loaded.
  - run falling while imem_ack arrives: fetch completes and the instruction executes.
- exec_en and rf_we are never high in the same cycle. rf_we is never asserted for JMP or NOP.

Decomposition:
- Shared package (microcpu_pkg):
  - opcode localparams NOP=0, ADD=1, SUB=2, MUL=3, AND=4, OR=5, JMP=6
  - sequencer state encoding
  - PC_WIDTH and INSTR_WIDTH defaults
- One sub-module, pc_reg: PC register with synchronous reset to PC_RESET, load (priority) and increment, wrapping.
- FSM, instruction register and retired counter stay in cpu_sequencer.

Test Plan:
- Reset then run=1, zero-wait memory, imem[0]=0x1123 (ADD r1,r2->r3) -> req at addr 0; exec_en cycle 3, rf_we cycle 4; pc=1, retired=1; next req at addr 1 in cycle 5.
- imem[1]=0x6040 (JMP 0x040), 2 wait cycles -> FETCH lasts 3 cycles with imem_addr=1 stable; exec_en pulse; no rf_we; pc=0x040; next fetch addr 0x040.
- pc at 0xFFF with NOP (0x0000) -> no rf_we; pc wraps to 0x000; retired++; 3-cycle instruction.
- Opcode 0xF123 -> treated as NOP: exec_en pulses, rf_we stays 0, pc+1.
- run dropped during DECODE of an ADD -> ADD completes with rf_we; sequencer enters IDLE with busy=0 and pc advanced; run=1 again resumes fetch at the new pc.
- rst asserted during a stalled FETCH (no ack) -> next cycle imem_req=0, pc=PC_RESET, retired=0, state IDLE; a late imem_ack is ignored.
